// File: rtl/chacha20_keystream_sequencer.sv
// ChaCha20 keystream sequencer: builds the initial state, runs the external round engine,
// adds the feed-forward and streams 16 words per block. Optional macro: CHACHA20_COUNTER_WRAP_ERROR_EN.
module chacha20_keystream_sequencer #(
    parameter int WORDS_PER_BLOCK = 16
) (
    input  logic         clock,
    input  logic         clear,
    input  logic [255:0] key,
    input  logic [95:0]  nonce,
    input  logic [31:0]  initial_counter,
    input  logic         load,
    input  logic         enable,
    output logic         core_start,
    output logic [511:0] core_round_input,
    input  logic         core_finished,
    input  logic [511:0] core_round_output,
    output logic         ks_valid,
    input  logic         ks_ready,
    output logic [31:0]  ks_data,
    output logic [31:0]  block_counter,
    output logic         busy,
    output logic         error,
    output logic [2:0]   dbg_state
);

    // Keystream handshake: a word transfers on a cycle where ks_valid && ks_ready;
    // ks_valid never drops and ks_data never changes until that transfer happens.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_ADD    = 3'd3,
        S_STREAM = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [255:0]  r_key;
    logic [95:0]   r_nonce;
    logic [31:0]   r_counter;
    logic          r_loaded;
    logic [31:0]   r_sum [0:WORDS_PER_BLOCK-1];
    logic [3:0]    r_idx;
    logic          w_last_accept;
    logic          w_wrap_stop;
    logic          w_blocked;

    assign core_round_input = {r_nonce, r_counter, r_key,
                               128'h6b206574_79622d32_3320646e_61707865};

    assign w_last_accept = (r_state == S_STREAM) && ks_ready &&
                           (r_idx == 4'(WORDS_PER_BLOCK - 1));

`ifdef CHACHA20_COUNTER_WRAP_ERROR_EN
    logic r_error;
    assign w_wrap_stop = (r_counter == 32'hFFFF_FFFF);
    assign w_blocked   = r_error;
    assign error       = r_error;

    always_ff @(posedge clock or posedge clear) begin
        if (clear)
            r_error <= 1'b0;
        else if (w_last_accept && w_wrap_stop)
            r_error <= 1'b1;
    end
`else
    assign w_wrap_stop = 1'b0;
    assign w_blocked   = 1'b0;
    assign error       = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (enable && (r_loaded || load) && !w_blocked) w_next = S_START;
            S_START:  w_next = S_WAIT;
            S_WAIT:   if (core_finished) w_next = S_ADD;
            S_ADD:    w_next = S_STREAM;
            S_STREAM: begin
                if (w_last_accept) begin
                    if (w_wrap_stop || !enable) w_next = S_IDLE;
                    else                        w_next = S_START;
                end
            end
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_state   <= S_IDLE;
            r_key     <= '0;
            r_nonce   <= '0;
            r_counter <= '0;
            r_loaded  <= 1'b0;
            r_idx     <= '0;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) r_sum[i] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && load) begin
                r_key     <= key;
                r_nonce   <= nonce;
                r_counter <= initial_counter;
                r_loaded  <= 1'b1;
            end
            // Feed-forward: engine output plus the state it started from, word by word.
            if (r_state == S_WAIT && core_finished) begin
                for (int i = 0; i < WORDS_PER_BLOCK; i++)
                    r_sum[i] <= core_round_output[32*i +: 32] + core_round_input[32*i +: 32];
            end
            if (r_state == S_STREAM && ks_ready) begin
                r_idx <= r_idx + 4'd1;
                if (w_last_accept) begin
                    r_idx <= '0;
                    if (!w_wrap_stop) r_counter <= r_counter + 32'd1;
                end
            end
        end
    end

    assign core_start    = (r_state == S_START);
    assign ks_valid      = (r_state == S_STREAM);
    assign ks_data       = ks_valid ? r_sum[r_idx] : 32'd0;
    assign block_counter = r_counter;
    assign busy          = (r_state != S_IDLE);
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_chacha20_keystream_sequencer.sv
// Bench for chacha20_keystream_sequencer: behavioural round engine, ChaCha20 block model,
// expected-word scoreboard and per-cycle compare process.
module tb_chacha20_keystream_sequencer;
  logic         clock = 0;
  logic         clear;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  initial_counter;
  logic         load, enable;
  logic         core_start;
  logic [511:0] core_round_input;
  logic         core_finished;
  logic [511:0] core_round_output;
  logic         ks_valid, ks_ready;
  logic [31:0]  ks_data, block_counter;
  logic         busy, error;
  logic [2:0]   dbg_state;

  chacha20_keystream_sequencer dut (
    .clock(clock), .clear(clear), .key(key), .nonce(nonce),
    .initial_counter(initial_counter), .load(load), .enable(enable),
    .core_start(core_start), .core_round_input(core_round_input),
    .core_finished(core_finished), .core_round_output(core_round_output),
    .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data),
    .block_counter(block_counter), .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // ChaCha20 model
  function automatic logic [127:0] qr(input logic [31:0] a, b, c, d);
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_rounds(input logic [511:0] st);
    logic [31:0] x [16];
    logic [127:0] q;
    logic [511:0] r;
    int ia, ib, ic, id;
    for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
    for (int dr = 0; dr < 10; dr++) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int j = 0; j < 4; j++) begin
          ia = j;
          ib = 4 + ((j + pass) % 4);
          ic = 8 + ((j + 2*pass) % 4);
          id = 12 + ((j + 3*pass) % 4);
          q = qr(x[ia], x[ib], x[ic], x[id]);
          x[ia] = q[127:96]; x[ib] = q[95:64]; x[ic] = q[63:32]; x[id] = q[31:0];
        end
      end
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = x[i];
    return r;
  endfunction

  function automatic logic [511:0] make_state(input logic [255:0] k, input logic [95:0] n,
                                              input logic [31:0] c);
    logic [511:0] s;
    s[31:0]   = 32'h61707865;
    s[63:32]  = 32'h3320646e;
    s[95:64]  = 32'h79622d32;
    s[127:96] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[32*(4+i) +: 32] = k[32*i +: 32];
    s[32*12 +: 32] = c;
    for (int i = 0; i < 3; i++) s[32*(13+i) +: 32] = n[32*i +: 32];
    return s;
  endfunction

  function automatic logic [31:0] ks_word(input logic [511:0] st, input int i);
    logic [511:0] r;
    r = chacha_rounds(st);
    return r[32*i +: 32] + st[32*i +: 32];
  endfunction

  // scoreboard: {block_counter, word}
  logic [63:0]  exp_q [$];
  logic [255:0] cur_key;
  logic [95:0]  cur_nonce;

  task automatic push_blocks(input logic [31:0] ctr, input int nblk);
    logic [511:0] st;
    logic [31:0] c;
    for (int b = 0; b < nblk; b++) begin
      c = ctr + 32'(b);
      st = make_state(cur_key, cur_nonce, c);
      for (int i = 0; i < 16; i++) exp_q.push_back({c, ks_word(st, i)});
    end
  endtask

  // behavioural round engine: finished high 10 cycles after the start cycle
  logic [511:0] eng_res;
  int eng_cnt;
  always @(posedge clock or posedge clear) begin
    if (clear) begin
      core_finished     <= 1'b1;
      core_round_output <= '0;
      eng_cnt           <= 0;
    end else if (core_start) begin
      core_finished     <= 1'b0;
      eng_cnt           <= 9;
      eng_res           <= chacha_rounds(core_round_input);
      core_round_output <= ~core_round_input;
    end else if (eng_cnt > 0) begin
      eng_cnt <= eng_cnt - 1;
      if (eng_cnt == 1) begin
        core_finished     <= 1'b1;
        core_round_output <= eng_res;
      end else begin
        core_round_output <= {16{$urandom}};
      end
    end
  end

  // random backpressure driver
  logic rand_ready = 0;
  always @(posedge clock) begin
    #1;
    if (rand_ready) ks_ready = 1'($urandom_range(0, 1));
  end

  // compare process
  int cyc = 0, start_cyc = 0, start_count = 0;
  logic first_pending = 0, prev_hold = 0;
  logic [31:0] prev_data = 0;
  logic [63:0] e;
  always @(negedge clock) begin
    cyc++;
    if (clear) begin
      first_pending = 0;
      prev_hold = 0;
    end else begin
      if (core_start) begin
        start_count++;
        start_cyc = cyc;
        first_pending = 1;
        if (exp_q.size() > 0)
          chk("core_round_input", core_round_input, make_state(cur_key, cur_nonce, exp_q[0][63:32]));
      end
      if (ks_valid) begin
        if (first_pending) begin
          chk("first_valid_latency", 512'(cyc - start_cyc), 512'd12);
          first_pending = 0;
        end
        if (prev_hold) chk("hold_stable", 512'(ks_data), 512'(prev_data));
        if (ks_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual %0h required none", ks_data);
          end else begin
            e = exp_q.pop_front();
            chk("ks_data", 512'(ks_data), 512'(e[31:0]));
            chk("block_counter", 512'(block_counter), 512'(e[63:32]));
          end
        end
      end
      prev_hold = ks_valid && !ks_ready;
      prev_data = ks_data;
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load_and_go(input logic [31:0] ctr);
    key = cur_key; nonce = cur_nonce; initial_counter = ctr;
    load = 1; enable = 1;
    step(1);
    load = 0;
  endtask

  task automatic wait_start(input int target);
    int n = 0;
    while (start_count < target && n < 500) begin step(1); n++; end
    if (start_count < target) begin
      checks++; errors++;
      $display("FAIL wait_start actual %0d required %0d", start_count, target);
    end
  endtask

  task automatic drain(input int qleft);
    int n = 0;
    while (exp_q.size() > qleft && n < 3000) begin step(1); n++; end
    if (exp_q.size() > qleft) begin
      checks++; errors++;
      $display("FAIL drain actual %0d required %0d", exp_q.size(), qleft);
      exp_q.delete();
    end
  endtask

  task automatic random_key_nonce();
    for (int i = 0; i < 8; i++) cur_key[32*i +: 32] = $urandom;
    for (int i = 0; i < 3; i++) cur_nonce[32*i +: 32] = $urandom;
  endtask

  logic [511:0] rst_st;
  logic [31:0]  rctr;
  int s0;

  initial begin
    clear = 1; load = 0; enable = 0; ks_ready = 0;
    key = '0; nonce = '0; initial_counter = '0;
    step(3);
    chk("rst_ks_valid", 512'(ks_valid), 512'd0);
    chk("rst_ks_data", 512'(ks_data), 512'd0);
    chk("rst_core_start", 512'(core_start), 512'd0);
    chk("rst_block_counter", 512'(block_counter), 512'd0);
    chk("rst_busy", 512'(busy), 512'd0);
    chk("rst_error", 512'(error), 512'd0);
    chk("rst_const_words", 512'(core_round_input[127:0]),
        512'(128'h6b206574_79622d32_3320646e_61707865));
    clear = 0;
    step(2);

    // RFC 8439 2.3.2 vector pins the model
    for (int i = 0; i < 32; i++) cur_key[8*i +: 8] = 8'(i);
    cur_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
    rst_st = make_state(cur_key, cur_nonce, 32'd1);
    chk("model_w0", 512'(ks_word(rst_st, 0)), 512'h e4e7f110);
    chk("model_w1", 512'(ks_word(rst_st, 1)), 512'h 15593bd1);
    chk("model_w2", 512'(ks_word(rst_st, 2)), 512'h 1fdd0f50);
    chk("model_w3", 512'(ks_word(rst_st, 3)), 512'h c47120a3);
    chk("model_w15", 512'(ks_word(rst_st, 15)), 512'h 4e3c50a2);

    // single RFC block, enable pulsed; loads during WAIT and STREAM are ignored
    ks_ready = 1;
    push_blocks(32'd1, 1);
    load_and_go(32'd1);
    enable = 0;
    wait_start(1);
    step(3);
    key = ~cur_key; initial_counter = 32'd55; load = 1;
    step(1);
    load = 0;
    drain(10);
    load = 1; nonce = ~cur_nonce;
    step(1);
    load = 0;
    drain(0);
    step(3);
    chk("t1_busy", 512'(busy), 512'd0);
    chk("t1_block_counter", 512'(block_counter), 512'd2);
    chk("t1_starts", 512'(start_count), 512'd1);

    // random backpressure, two blocks
    random_key_nonce();
    rctr = $urandom;
    s0 = start_count;
    push_blocks(rctr, 2);
    rand_ready = 1;
    load_and_go(rctr);
    wait_start(s0 + 2);
    enable = 0;
    drain(0);
    rand_ready = 0;
    step(2);
    ks_ready = 1;
    step(2);
    chk("t2_busy", 512'(busy), 512'd0);
    chk("t2_block_counter", 512'(block_counter), 512'(rctr + 32'd2));
    chk("t2_starts", 512'(start_count - s0), 512'd2);

    // three back-to-back blocks from counter 1
    random_key_nonce();
    s0 = start_count;
    push_blocks(32'd1, 3);
    load_and_go(32'd1);
    wait_start(s0 + 3);
    enable = 0;
    drain(0);
    step(3);
    chk("t3_starts", 512'(start_count - s0), 512'd3);
    chk("t3_block_counter", 512'(block_counter), 512'd4);

    // clear while word 7 is on the bus
    random_key_nonce();
    push_blocks(32'd9, 1);
    load_and_go(32'd9);
    enable = 0;
    drain(9);
    #2 clear = 1;
    #1;
    exp_q.delete();
    chk("clr_ks_valid", 512'(ks_valid), 512'd0);
    chk("clr_ks_data", 512'(ks_data), 512'd0);
    chk("clr_busy", 512'(busy), 512'd0);
    chk("clr_block_counter", 512'(block_counter), 512'd0);
    chk("clr_core_start", 512'(core_start), 512'd0);
    step(1);
    clear = 0;
    enable = 1;
    s0 = start_count;
    step(4);
    chk("noload_busy", 512'(busy), 512'd0);
    chk("noload_starts", 512'(start_count - s0), 512'd0);
    enable = 0;
    random_key_nonce();
    rctr = $urandom;
    push_blocks(rctr, 1);
    load_and_go(rctr);
    enable = 0;
    drain(0);
    step(3);
    chk("reload_block_counter", 512'(block_counter), 512'(rctr + 32'd1));

    // counter wrap
    random_key_nonce();
    s0 = start_count;
`ifdef CHACHA20_COUNTER_WRAP_ERROR_EN
    push_blocks(32'hFFFF_FFFF, 1);
    load_and_go(32'hFFFF_FFFF);
    drain(0);
    step(6);
    chk("wrap_error", 512'(error), 512'd1);
    chk("wrap_busy", 512'(busy), 512'd0);
    chk("wrap_starts", 512'(start_count - s0), 512'd1);
    chk("wrap_block_counter", 512'(block_counter), 512'hFFFF_FFFF);
    initial_counter = 32'd3; load = 1;
    step(1);
    load = 0;
    step(4);
    chk("wrap_hold_busy", 512'(busy), 512'd0);
    chk("wrap_hold_error", 512'(error), 512'd1);
    enable = 0;
`else
    push_blocks(32'hFFFF_FFFF, 2);
    load_and_go(32'hFFFF_FFFF);
    wait_start(s0 + 2);
    enable = 0;
    drain(0);
    step(3);
    chk("wrap_error", 512'(error), 512'd0);
    chk("wrap_starts", 512'(start_count - s0), 512'd2);
    chk("wrap_block_counter", 512'(block_counter), 512'd1);
`endif
    chk("final_queue_empty", 512'(exp_q.size()), 512'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
